// File: rtl/instr_exec_unit.sv
// Two-stage execute/writeback unit: stage 1 decodes and reads operands,
// stage 2 runs the ALU and writes back the register file, flags and rout.
module instr_exec_unit #(
    parameter int NREGS = 16,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [WIDTH-1:0] rout,
    output logic             wb_valid,
    output logic [3:0]       wb_reg,
    output logic [4:0]       flags,
    output logic             illegal,
    input  logic [3:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [3:0] {
        OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP,
        OP_AND, OP_OR, OP_XOR, OP_MOV, OP_ILL
    } op_e;

    // flag bit positions within {Z, C, F, L, N}
    localparam int FZ = 4;
    localparam int FC = 3;
    localparam int FF = 2;
    localparam int FL = 1;
    localparam int FN = 0;

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] r_rout;
    logic [4:0]       r_flags;
    logic             r_wb_valid;
    logic [3:0]       r_wb_reg;
    logic             r_illegal;

    logic             r_s1_valid;
    op_e              r_s1_op;
    logic [3:0]       r_s1_dest;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_cin;

    op_e              w_op;
    logic             w_use_imm;
    logic [WIDTH-1:0] w_imm;
    logic [3:0]       w_dest;
    logic [3:0]       w_src;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_rs;
    logic [WIDTH-1:0] w_b;
    logic             w_accept;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_ex_res;
    logic             w_ex_we;
    logic [4:0]       w_flg;

    assign instr_ready = reset;
    assign w_accept    = instr_valid & instr_ready;
    assign w_dest      = instr[11:8];
    assign w_src       = instr[3:0];

    always_comb begin
        w_op      = OP_ILL;
        w_use_imm = 1'b0;
        w_imm     = {{(WIDTH-8){instr[7]}}, instr[7:0]};
        case (instr[15:12])
            4'b0000: begin
                case (instr[7:4])
                    4'b0101: w_op = OP_ADD;
                    4'b0111: w_op = OP_ADDC;
                    4'b1001: w_op = OP_SUB;
                    4'b1010: w_op = OP_SUBC;
                    4'b1011: w_op = OP_CMP;
                    4'b0001: w_op = OP_AND;
                    4'b0010: w_op = OP_OR;
                    4'b0011: w_op = OP_XOR;
                    4'b1101: w_op = OP_MOV;
                    default: w_op = OP_ILL;
                endcase
            end
            4'b0101: begin w_op = OP_ADD; w_use_imm = 1'b1; end
            4'b1001: begin w_op = OP_SUB; w_use_imm = 1'b1; end
            4'b1011: begin w_op = OP_CMP; w_use_imm = 1'b1; end
            4'b1101: begin w_op = OP_MOV; w_use_imm = 1'b1; end
            4'b1111: begin
                w_op      = OP_MOV;
                w_use_imm = 1'b1;
                w_imm     = {instr[7:0], {(WIDTH-8){1'b0}}};
            end
            default: w_op = OP_ILL;
        endcase
    end

    // Operands forward from the stage-2 result when it targets the same register
    assign w_a  = (w_ex_we && (r_s1_dest == w_dest)) ? w_ex_res : r_regs[w_dest];
    assign w_rs = (w_ex_we && (r_s1_dest == w_src))  ? w_ex_res : r_regs[w_src];
    assign w_b  = w_use_imm ? w_imm : w_rs;

    assign w_add = {1'b0, r_s1_a} + {1'b0, r_s1_b}
                 + {{WIDTH{1'b0}}, (r_s1_op == OP_ADDC) & r_s1_cin};
    assign w_sub = {1'b0, r_s1_a} - {1'b0, r_s1_b}
                 - {{WIDTH{1'b0}}, (r_s1_op == OP_SUBC) & r_s1_cin};

    always_comb begin
        w_ex_res = '0;
        w_ex_we  = 1'b0;
        w_flg    = r_flags;
        if (r_s1_valid) begin
            case (r_s1_op)
                OP_ADD, OP_ADDC: begin
                    w_ex_res  = w_add[WIDTH-1:0];
                    w_ex_we   = 1'b1;
                    w_flg[FC] = w_add[WIDTH];
                    w_flg[FF] = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                                (w_add[WIDTH-1] != r_s1_a[WIDTH-1]);
                    w_flg[FZ] = (w_add[WIDTH-1:0] == '0);
                    w_flg[FN] = w_add[WIDTH-1];
                end
                OP_SUB, OP_SUBC: begin
                    w_ex_res  = w_sub[WIDTH-1:0];
                    w_ex_we   = 1'b1;
                    w_flg[FC] = w_sub[WIDTH];
                    w_flg[FF] = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                                (w_sub[WIDTH-1] != r_s1_a[WIDTH-1]);
                    w_flg[FZ] = (w_sub[WIDTH-1:0] == '0);
                    w_flg[FN] = w_sub[WIDTH-1];
                end
                OP_CMP: begin
                    w_flg[FZ] = (w_sub[WIDTH-1:0] == '0);
                    w_flg[FN] = w_sub[WIDTH-1];
                    w_flg[FL] = (r_s1_a < r_s1_b);
                end
                OP_AND, OP_OR, OP_XOR: begin
                    if (r_s1_op == OP_AND)     w_ex_res = r_s1_a & r_s1_b;
                    else if (r_s1_op == OP_OR) w_ex_res = r_s1_a | r_s1_b;
                    else                       w_ex_res = r_s1_a ^ r_s1_b;
                    w_ex_we   = 1'b1;
                    w_flg[FZ] = (w_ex_res == '0);
                    w_flg[FN] = w_ex_res[WIDTH-1];
                end
                OP_MOV: begin
                    w_ex_res = r_s1_b;
                    w_ex_we  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_rout     <= '0;
            r_flags    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_reg   <= '0;
            r_illegal  <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_ILL;
            r_s1_dest  <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_cin   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_op   <= w_op;
                r_s1_dest <= w_dest;
                r_s1_a    <= w_a;
                r_s1_b    <= w_b;
                r_s1_cin  <= w_flg[FC];
            end
            if (w_ex_we) begin
                r_regs[r_s1_dest] <= w_ex_res;
                r_rout            <= w_ex_res;
                r_wb_reg          <= r_s1_dest;
            end
            r_wb_valid <= w_ex_we;
            r_flags    <= w_flg;
            r_illegal  <= r_s1_valid && (r_s1_op == OP_ILL);
        end
    end

    assign rout     = r_rout;
    assign wb_valid = r_wb_valid;
    assign wb_reg   = r_wb_reg;
    assign flags    = r_flags;
    assign illegal  = r_illegal;
    assign dbg_data = r_regs[dbg_sel];

endmodule
